// File: rtl/isp_pkg.sv
// rtl/isp_pkg.sv - shared capture FSM states and default frame geometry
package isp_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    WAIT_VS = 2'd2,
    CAPTURE = 2'd3
  } wr_state_t;

  localparam int DEF_H_PIXELS    = 640;
  localparam int DEF_V_LINES     = 480;
  localparam int DEF_SKIP_FRAMES = 10;
endpackage

// File: rtl/sig_edge_det.sv
// rtl/sig_edge_det.sv - rise/fall detector against a single registered copy of the input
module sig_edge_det (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic sig_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) sig_d <= 1'b0;
    else         sig_d <= sig;
  end

  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;
endmodule

// File: rtl/cmos_wr_pack.sv
// rtl/cmos_wr_pack.sv - packs camera byte pairs into write-FIFO pixels with frame skip and ping-pong half select
// Optional geometry checking (frame_err, no ping-pong flip on bad frames) under CMOS_FRAME_CHECK_EN.
module cmos_wr_pack
  import isp_pkg::*;
#(
  parameter int H_PIXELS    = DEF_H_PIXELS,
  parameter int V_LINES     = DEF_V_LINES,
  parameter int SKIP_FRAMES = DEF_SKIP_FRAMES
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        pingpang_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_byte_en,
  input  logic [7:0]  cam_data,
  output logic        wr_fifo_wr_req,
  output logic [15:0] wr_fifo_wr_data,
  output logic        wr_rst,
  output logic        pic_c,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        frame_err
);
  localparam int PIX_W  = $clog2(H_PIXELS) + 1;
  localparam int LINE_W = $clog2(V_LINES) + 1;

  wr_state_t         state;
  logic [7:0]        skip_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              phase;
  logic [7:0]        hi_byte;

  logic vs_rise, vs_fall, hr_rise, hr_fall, edge_unused;

  sig_edge_det u_vs_edge (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .sig     (cam_vsync),
    .rise    (vs_rise),
    .fall    (vs_fall)
  );

  sig_edge_det u_hr_edge (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .sig     (cam_href),
    .rise    (hr_rise),
    .fall    (hr_fall)
  );

  assign edge_unused = vs_fall | hr_rise;

  logic              byte_ok, frame_end, frame_bad, start_frame;
  logic [LINE_W-1:0] lines_now;

  assign byte_ok   = cam_byte_en & cam_href;
  assign lines_now = line_cnt + LINE_W'(hr_fall);
  assign frame_end = (state == CAPTURE) &
                     (vs_rise | (hr_fall & (lines_now == LINE_W'(V_LINES))));
  // skip_cnt counts edges already seen, so capture begins on edge SKIP_FRAMES+1
  assign start_frame = vs_rise & ((state == WAIT_VS) | (state == CAPTURE) |
                                  ((state == SKIP) & (skip_cnt == 8'(SKIP_FRAMES))));

`ifdef CMOS_FRAME_CHECK_EN
  logic line_bad, line_err;

  // a dangling odd byte also marks the line as malformed
  assign line_bad = hr_fall & (phase | (pix_cnt != PIX_W'(H_PIXELS)));

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !init_end || start_frame) line_err <= 1'b0;
    else if (state == CAPTURE && line_bad)   line_err <= 1'b1;
  end

  assign frame_bad = line_err | line_bad | (lines_now != LINE_W'(V_LINES));
`else
  assign frame_bad = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state           <= IDLE;
      skip_cnt        <= '0;
      pix_cnt         <= '0;
      line_cnt        <= '0;
      phase           <= 1'b0;
      hi_byte         <= '0;
      wr_fifo_wr_req  <= 1'b0;
      wr_fifo_wr_data <= '0;
      wr_rst          <= 1'b0;
      pic_c           <= 1'b0;
      frame_done      <= 1'b0;
      frame_cnt       <= '0;
      frame_err       <= 1'b0;
    end else begin
      wr_fifo_wr_req <= 1'b0;
      wr_rst         <= 1'b0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
      if (!init_end) begin
        state    <= IDLE;
        skip_cnt <= '0;
        pix_cnt  <= '0;
        line_cnt <= '0;
        phase    <= 1'b0;
      end else begin
        case (state)
          IDLE:    state <= (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
          SKIP:    if (vs_rise) skip_cnt <= skip_cnt + 8'd1;
          default: ;
        endcase

        if (state == CAPTURE && byte_ok) begin
          phase <= ~phase;
          if (!phase) begin
            hi_byte <= cam_data;
          end else begin
            wr_fifo_wr_req  <= 1'b1;
            wr_fifo_wr_data <= {hi_byte, cam_data};
            if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
          end
        end

        if (state == CAPTURE && hr_fall) begin
          phase    <= 1'b0;
          pix_cnt  <= '0;
          line_cnt <= lines_now;
        end

        if (frame_end) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
          frame_err  <= frame_bad;
          if (pingpang_en && !frame_bad) pic_c <= ~pic_c;
          state    <= WAIT_VS;
          pix_cnt  <= '0;
          line_cnt <= '0;
          phase    <= 1'b0;
        end

        // a vsync edge that ends a frame also opens the next one
        if (start_frame) begin
          wr_rst   <= 1'b1;
          state    <= CAPTURE;
          skip_cnt <= '0;
          pix_cnt  <= '0;
          line_cnt <= '0;
          phase    <= 1'b0;
        end
      end
    end
  end
endmodule
